// File: rtl/cnn_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cnn_frame_ctrl_pkg
//  Purpose : Shared definitions for the stage-1 frame sequencer: stage-1
//            core widths, shadow image size, FSM state encoding and helper
//            functions for derived sizes.
//  Macros  : none (the timeout option CNN_CTRL_TIMEOUT_EN lives in the top)
//  Rev     : 1.0  initial release
// ============================================================================
package cnn_frame_ctrl_pkg;

   // Stage-1 core geometry and field widths.
   localparam int ST1_CO   = 3;
   localparam int ST1_CI   = 1;
   localparam int KX       = 3;
   localparam int KY       = 3;
   localparam int ST1_W_BW = 8;
   localparam int ST1_B_BW = 16;

   // Shadow image layout: weights in the low bits, biases on top.
   localparam int W_BITS  = ST1_CO * ST1_CI * KX * KY * ST1_W_BW;
   localparam int B_BITS  = ST1_CO * ST1_B_BW;
   localparam int CFG_TOT = W_BITS + B_BITS;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR    = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Number of valid convolution outputs for a frame (no padding, stride 1).
   function automatic int calc_n_out(input int w, input int h, input int k);
      return (w - k + 1) * (h - k + 1);
   endfunction

   // Number of config words needed to cover the whole shadow image.
   function automatic int calc_words(input int tot, input int bw);
      return (tot + bw - 1) / bw;
   endfunction

   localparam int N_OUT = calc_n_out(28, 28, KX);

endpackage
`default_nettype wire

// File: rtl/cnn_frame_ctrl_cfg_shadow.sv
`default_nettype none
// ============================================================================
//  Module  : cnn_cfg_shadow
//  Purpose : Word-indexed weight/bias shadow register. Word k of a load is
//            written to shadow[k*CFG_BW +: CFG_BW] (the last word truncated
//            at CFG_TOT). o_cfg_ok rises the cycle after the final word and
//            further words are ignored until the next i_first.
//  Ports   : clk, reset        clock, synchronous active-high reset
//            i_wr_en           config word strobe (already gated to IDLE)
//            i_first           word is word 0 of a new load
//            i_data[CFG_BW]    config word
//            o_shadow[CFG_TOT] shadow image
//            o_cfg_ok          full image loaded
//  Rev     : 1.0  initial release
// ============================================================================
module cnn_cfg_shadow
   import cnn_frame_ctrl_pkg::*;
#(
   parameter int CFG_BW  = 32,
   parameter int CFG_TOT = 264
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_wr_en,
   input  logic               i_first,
   input  logic [CFG_BW-1:0]  i_data,
   output logic [CFG_TOT-1:0] o_shadow,
   output logic               o_cfg_ok
);

   localparam int N_WORDS = calc_words(CFG_TOT, CFG_BW);
   localparam int IDX_BW  = $clog2(N_WORDS + 1);

   logic [IDX_BW-1:0]  idx_q, idx_d;
   logic               ok_q, ok_d;
   logic [CFG_TOT-1:0] shadow_q, shadow_d;
   logic [IDX_BW-1:0]  w_wr_idx;
   logic               w_wr;
   logic [CFG_TOT-1:0] w_rep;
   logic [CFG_TOT-1:0] w_mask;

   // A first-word strobe always restarts at word 0, even after a full load.
   assign w_wr_idx = i_first ? '0 : idx_q;
   assign w_wr     = i_wr_en & (i_first | ~ok_q);

   // The config word replicated across the image, and a mask selecting the
   // bits of the word currently addressed; the top word is naturally cut
   // off at CFG_TOT.
   for (genvar b = 0; b < CFG_TOT; b++) begin : g_bit
      assign w_rep[b]  = i_data[b % CFG_BW];
      assign w_mask[b] = (w_wr_idx == IDX_BW'(b / CFG_BW));
   end

   always_comb begin
      idx_d    = idx_q;
      ok_d     = ok_q;
      shadow_d = shadow_q;
      if (w_wr) begin
         shadow_d = (shadow_q & ~w_mask) | (w_rep & w_mask);
         idx_d    = w_wr_idx + 1'b1;
         ok_d     = (w_wr_idx == IDX_BW'(N_WORDS - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q    <= '0;
         ok_q     <= 1'b0;
         shadow_q <= '0;
      end else begin
         idx_q    <= idx_d;
         ok_q     <= ok_d;
         shadow_q <= shadow_d;
      end
   end

   assign o_shadow = shadow_q;
   assign o_cfg_ok = ok_q;

endmodule
`default_nettype wire

// File: rtl/cnn_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : cnn_frame_ctrl
//  Purpose : Frame sequencer for the stage-1 convolution core. Holds the
//            weight/bias shadow image, and per frame clears the core, streams
//            IMG_W*IMG_H pixels from frame RAM, then counts the core's output
//            valid pulses before reporting done.
//  Macro   : CNN_CTRL_TIMEOUT_EN - enables the DRAIN idle timeout (TMO_CYC);
//            when undefined o_err is constant 0 and DRAIN waits indefinitely.
//  Ports   : clk, reset                  clock, synchronous active-high reset
//            i_cfg_valid/first/data      config word port
//            o_cfg_ok                    shadow image complete
//            o_cnn_weight, o_cnn_bias    shadow fields to the core
//            i_start, i_abort            frame start / abort
//            o_rd_en, o_rd_addr, i_rd_data  frame RAM read port (1-cycle)
//            o_core_rst_n                active-low clear to the core
//            o_in_valid, o_in_fmap       pixel stream to the core
//            i_ot_valid                  core output valid
//            o_busy, o_done, o_err       status to system controller
//  Rev     : 1.0  initial release
// ============================================================================
module cnn_frame_ctrl
   import cnn_frame_ctrl_pkg::*;
#(
   parameter int IMG_W   = 28,
   parameter int IMG_H   = 28,
   parameter int KW      = 3,
   parameter int PIX_BW  = 8,
   parameter int ADDR_BW = 10,
   parameter int CFG_BW  = 32,
   parameter int TMO_CYC = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_cfg_valid,
   input  logic              i_cfg_first,
   input  logic [CFG_BW-1:0] i_cfg_data,
   output logic              o_cfg_ok,
   output logic [W_BITS-1:0] o_cnn_weight,
   output logic [B_BITS-1:0] o_cnn_bias,
   input  logic              i_start,
   input  logic              i_abort,
   output logic              o_rd_en,
   output logic [ADDR_BW-1:0] o_rd_addr,
   input  logic [PIX_BW-1:0] i_rd_data,
   output logic              o_core_rst_n,
   output logic              o_in_valid,
   output logic [PIX_BW-1:0] o_in_fmap,
   input  logic              i_ot_valid,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   localparam int N_PIX     = IMG_W * IMG_H;
   localparam int N_OUT_CUR = calc_n_out(IMG_W, IMG_H, KW);
   localparam int OCNT_BW   = $clog2(N_OUT_CUR + 1);

   state_e              state_q, state_d;
   logic [ADDR_BW-1:0]  addr_q, addr_d;
   logic [OCNT_BW-1:0]  out_cnt_q, out_cnt_d;
   logic                in_valid_q;
   logic                core_rst_n_q;
   logic                err_q, err_d;
   logic                w_tmo_hit;
   logic [CFG_TOT-1:0]  w_shadow;
   logic                w_cfg_wr;

   // Config writes only in IDLE, so the core sees a stable image mid-frame.
   assign w_cfg_wr = i_cfg_valid & (state_q == ST_IDLE);

   cnn_cfg_shadow #(
      .CFG_BW  (CFG_BW),
      .CFG_TOT (CFG_TOT)
   ) u_shadow (
      .clk      (clk),
      .reset    (reset),
      .i_wr_en  (w_cfg_wr),
      .i_first  (i_cfg_first),
      .i_data   (i_cfg_data),
      .o_shadow (w_shadow),
      .o_cfg_ok (o_cfg_ok)
   );

   assign o_cnn_weight = w_shadow[W_BITS-1:0];
   assign o_cnn_bias   = w_shadow[CFG_TOT-1 -: B_BITS];

`ifdef CNN_CTRL_TIMEOUT_EN
   localparam int TMO_BW = $clog2(TMO_CYC + 1);

   logic [TMO_BW-1:0] tmo_q, tmo_d;

   // Counts DRAIN cycles since the last output valid; the valid cycle itself
   // counts as 1 so the hit lands TMO_CYC cycles after the last pulse.
   always_comb begin
      tmo_d = '0;
      if (state_q == ST_DRAIN && !i_abort) begin
         tmo_d = i_ot_valid ? TMO_BW'(1) : tmo_q + 1'b1;
      end
   end

   assign w_tmo_hit = (state_q == ST_DRAIN) && (tmo_d == TMO_BW'(TMO_CYC));

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      out_cnt_d = out_cnt_q;
      err_d     = 1'b0;

      // Output pulses saturate at N_OUT; extras are dropped.
      if ((state_q == ST_STREAM || state_q == ST_DRAIN) && i_ot_valid &&
          out_cnt_q != OCNT_BW'(N_OUT_CUR)) begin
         out_cnt_d = out_cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (i_start && o_cfg_ok && !i_abort) begin
               state_d = ST_CLR;
            end
         end
         ST_CLR: begin
            addr_d    = '0;
            out_cnt_d = '0;
            state_d   = ST_STREAM;
         end
         ST_STREAM: begin
            if (addr_q == ADDR_BW'(N_PIX - 1)) begin
               addr_d  = '0;
               state_d = ST_DRAIN;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (out_cnt_q == OCNT_BW'(N_OUT_CUR)) begin
               state_d = ST_DONE;
            end else if (w_tmo_hit) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (i_abort && state_q != ST_IDLE) begin
         state_d   = ST_IDLE;
         addr_d    = '0;
         out_cnt_d = '0;
         err_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         out_cnt_q    <= '0;
         in_valid_q   <= 1'b0;
         core_rst_n_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         out_cnt_q    <= out_cnt_d;
         // RAM data arrives one cycle after the read; an abort kills it.
         in_valid_q   <= (state_q == ST_STREAM) && !i_abort;
         core_rst_n_q <= (state_d != ST_CLR);
         err_q        <= err_d;
      end
   end

   assign o_rd_en      = (state_q == ST_STREAM);
   assign o_rd_addr    = addr_q;
   assign o_in_valid   = in_valid_q;
   assign o_in_fmap    = i_rd_data;
   assign o_core_rst_n = core_rst_n_q;
   assign o_busy       = (state_q != ST_IDLE);
   assign o_done       = (state_q == ST_DONE);
   assign o_err        = err_q;

endmodule
`default_nettype wire
